// File: rtl/uart_msg_arbiter_if.sv
// rtl/uart_msg_arbiter_if.sv - source/sink stream bundle around uart_msg_arbiter
//
// Groups every handshake and status signal of the arbiter.
//   slave  modport : the arbiter's view (sources in, uart_tx sink out, status out)
//   master modport : the surrounding system's view (drives sources and m_tready)
// Signals:
//   s_tdata  [N_SRC*N_BITS] source bytes, source k at [k*N_BITS +: N_BITS]
//   s_tvalid/s_tlast/s_tready [N_SRC] per-source handshake
//   m_tdata/m_tvalid/m_tready shared byte stream towards uart_tx
//   grant [GW] current or last owner, busy, msg_done, abort status
interface uart_msg_arbiter_if #(
    parameter int N_SRC  = 2,
    parameter int N_BITS = 8
);
    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC*N_BITS-1:0] s_tdata;
    logic [N_SRC-1:0]        s_tvalid;
    logic [N_SRC-1:0]        s_tlast;
    logic [N_SRC-1:0]        s_tready;
    logic [N_BITS-1:0]       m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [GW-1:0]           grant;
    logic                    busy;
    logic                    msg_done;
    logic                    abort;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, grant, busy, msg_done, abort
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, grant, busy, msg_done, abort
    );
endinterface

// File: rtl/uart_msg_arbiter.sv
// rtl/uart_msg_arbiter.sv - round-robin, message-granular arbiter sharing one uart_tx stream
//
// A source keeps the grant from its first byte until its tlast byte is accepted,
// so messages never interleave. A grant is also dropped after MAX_LEN bytes or
// after TIMEOUT consecutive cycles with the owner's s_tvalid low (watchdog).
// Ports:
//   clk        single rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus.slave  s_tdata/s_tvalid/s_tlast in, s_tready out (per source);
//              m_tdata/m_tvalid out, m_tready in (towards uart_tx);
//              grant, busy, msg_done, abort status out
module uart_msg_arbiter #(
    parameter int N_SRC   = 2,
    parameter int N_BITS  = 8,
    parameter int TIMEOUT = 1_000_000,
    parameter int MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_msg_arbiter_if.slave bus
);
    localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int SW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int BW = ($clog2(MAX_LEN + 1) > 1) ? $clog2(MAX_LEN + 1) : 1;

    // The release fires when the counter already holds limit-1 and the
    // current cycle completes the limit.
    localparam logic [SW-1:0] STALL_LIM = (TIMEOUT == 0) ? SW'(0) : SW'(TIMEOUT - 1);
    localparam logic [BW-1:0] LEN_LIM   = BW'(MAX_LEN - 1);
    localparam logic [BW-1:0] LEN_SAT   = BW'(MAX_LEN);

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     last_q;
    logic [SW-1:0]     stall_cnt;
    logic [BW-1:0]     byte_cnt;
    logic              msg_done_q;
    logic              abort_q;

    logic              xfer;
    logic              hs;
    logic              any_req;
    logic [N_BITS-1:0] cur_data;
    logic              cur_valid;
    logic              cur_last;
    logic [N_SRC-1:0]  tready_c;
    logic              found_hi;
    logic              found_lo;
    logic [GW-1:0]     win_hi;
    logic [GW-1:0]     win_lo;
    logic [GW-1:0]     winner;

    assign xfer    = (state == XFER);
    assign any_req = |bus.s_tvalid;
    assign hs      = xfer & cur_valid & bus.m_tready;

    // Data path: plain mux of the granted source, no pipeline register.
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        tready_c  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (GW'(i) == grant_q) begin
                cur_data    = bus.s_tdata[i*N_BITS +: N_BITS];
                cur_valid   = bus.s_tvalid[i];
                cur_last    = bus.s_tlast[i];
                tready_c[i] = xfer & bus.m_tready;
            end
        end
    end

    // Round-robin pick: the lowest requester above last_q wins; if there is
    // none, the scan wraps and the lowest requester overall wins.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.s_tvalid[i] && (i > int'(last_q)) && !found_hi) begin
                found_hi = 1'b1;
                win_hi   = GW'(i);
            end
            if (bus.s_tvalid[i] && !found_lo) begin
                found_lo = 1'b1;
                win_lo   = GW'(i);
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_q    <= '0;
            last_q     <= GW'(N_SRC - 1);
            stall_cnt  <= '0;
            byte_cnt   <= '0;
            msg_done_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            msg_done_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q   <= winner;
                        state     <= XFER;
                        stall_cnt <= '0;
                        byte_cnt  <= '0;
                    end
                end
                XFER: begin
                    if (hs && (byte_cnt != LEN_SAT)) begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    // Only a missing source byte is a stall; m_tready low is not.
                    if (cur_valid) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                    // tlast takes priority so a message ending exactly at
                    // MAX_LEN completes normally.
                    if (hs && cur_last) begin
                        state      <= IDLE;
                        last_q     <= grant_q;
                        msg_done_q <= 1'b1;
                    end else if (hs && (byte_cnt == LEN_LIM)) begin
                        state   <= IDLE;
                        last_q  <= grant_q;
                        abort_q <= 1'b1;
                    end else if ((TIMEOUT != 0) && !cur_valid && (stall_cnt == STALL_LIM)) begin
                        state   <= IDLE;
                        last_q  <= grant_q;
                        abort_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_tdata  = xfer ? cur_data : '0;
    assign bus.m_tvalid = xfer & cur_valid;
    assign bus.s_tready = tready_c;
    assign bus.grant    = grant_q;
    assign bus.busy     = xfer;
    assign bus.msg_done = msg_done_q;
    assign bus.abort    = abort_q;
endmodule

// File: tb/tb_uart_msg_arbiter.sv
// tb/tb_uart_msg_arbiter.sv - self-checking bench for uart_msg_arbiter
module tb_uart_msg_arbiter;
    localparam int NS = 3;
    localparam int NB = 8;
    localparam int TO = 10;
    localparam int ML = 8;

    typedef struct {
        logic [7:0] data;
        bit         last;
        int         gap;
    } ent_t;

    typedef struct {
        int         src;
        logic [7:0] data;
        int         cyc;
    } hs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_msg_arbiter_if #(.N_SRC(NS), .N_BITS(NB)) bus();

    uart_msg_arbiter #(.N_SRC(NS), .N_BITS(NB), .TIMEOUT(TO), .MAX_LEN(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ent_t       srcq[NS][$];
    logic [7:0] exp_bytes[NS][$];
    int         gap_left[NS];
    bit         loaded[NS];
    hs_t        hs_log[$];
    int         grant_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt, abort_cnt, last_done_cyc, last_abort_cyc, bad_rdy;
    bit prev_busy, rand_ready;

    // Reference model: owner (-1 when idle), round-robin pointer, per-message counts.
    int m_own, m_last, m_ghold, m_bytes, m_stall, m_done_n, m_abort_n;
    bit e_done, e_abort;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(int k, logic [7:0] d, bit l, int g);
        srcq[k].push_back('{data: d, last: l, gap: g});
        exp_bytes[k].push_back(d);
    endtask

    task automatic push_rand_msg(int k, int len);
        for (int i = 0; i < len; i++) begin
            push(k, 8'($urandom_range(255)), (i == len - 1),
                 ($urandom_range(3) == 0) ? int'($urandom_range(14, 1)) : 0);
        end
    endtask

    function automatic bit pending();
        for (int k = 0; k < NS; k++) begin
            if (srcq[k].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive(logic [NS-1:0] popv);
        for (int k = 0; k < NS; k++) begin
            if (popv[k] && srcq[k].size() > 0) begin
                void'(srcq[k].pop_front());
                loaded[k] = 1'b0;
            end
            if (srcq[k].size() > 0) begin
                if (!loaded[k]) begin
                    gap_left[k] = srcq[k][0].gap;
                    loaded[k]   = 1'b1;
                end
                bus.s_tdata[k*NB +: NB] = srcq[k][0].data;
                bus.s_tlast[k]          = srcq[k][0].last;
                if (gap_left[k] > 0) begin
                    bus.s_tvalid[k] = 1'b0;
                    gap_left[k]--;
                end else begin
                    bus.s_tvalid[k] = 1'b1;
                end
            end else begin
                bus.s_tvalid[k] = 1'b0;
                bus.s_tlast[k]  = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(logic [NS-1:0] sv, logic mr);
        logic [NS-1:0] er;
        chk("busy", bus.busy, (m_own >= 0));
        chk("msg_done", bus.msg_done, e_done);
        chk("abort", bus.abort, e_abort);
        if (m_own >= 0) begin
            er = '0;
            er[m_own] = mr;
            chk("grant", bus.grant, m_own);
            chk("m_tvalid", bus.m_tvalid, sv[m_own]);
            chk("m_tdata", bus.m_tdata, bus.s_tdata[m_own*NB +: NB]);
            chk("s_tready", bus.s_tready, er);
        end else begin
            chk("grant_hold", bus.grant, m_ghold);
            chk("idle_m_tvalid", bus.m_tvalid, 0);
            chk("idle_s_tready", bus.s_tready, 0);
            chk("idle_m_tdata", bus.m_tdata, 0);
        end
    endtask

    task automatic model_release();
        m_last = m_own;
        m_own  = -1;
    endtask

    task automatic model_step(logic [NS-1:0] sv, logic [NS-1:0] sl, logic mr);
        bit found;
        e_done  = 1'b0;
        e_abort = 1'b0;
        if (m_own < 0) begin
            found = 1'b0;
            for (int off = 1; off <= NS; off++) begin
                int c;
                c = (m_last + off) % NS;
                if (!found && sv[c]) begin
                    found   = 1'b1;
                    m_own   = c;
                    m_ghold = c;
                    m_bytes = 0;
                    m_stall = 0;
                end
            end
        end else begin
            if (sv[m_own]) m_stall = 0;
            else           m_stall++;
            if (sv[m_own] && mr) begin
                m_bytes++;
                if (sl[m_own]) begin
                    e_done = 1'b1;
                    m_done_n++;
                    model_release();
                end else if (m_bytes == ML) begin
                    e_abort = 1'b1;
                    m_abort_n++;
                    model_release();
                end
            end else if (!sv[m_own] && TO != 0 && m_stall >= TO) begin
                e_abort = 1'b1;
                m_abort_n++;
                model_release();
            end
        end
    endtask

    task automatic cycle();
        logic [NS-1:0] sv, sl, popv;
        logic          mr;
        @(negedge clk);
        sv = bus.s_tvalid;
        sl = bus.s_tlast;
        mr = bus.m_tready;
        check_outputs(sv, mr);
        if (bus.busy && !prev_busy) grant_log.push_back(int'(bus.grant));
        prev_busy = bus.busy;
        if (bus.m_tvalid && mr) hs_log.push_back('{src: int'(bus.grant), data: bus.m_tdata, cyc: cyc});
        if (bus.busy && bus.grant == 0 && bus.s_tready[1]) bad_rdy++;
        if (bus.msg_done) begin done_cnt++;  last_done_cyc  = cyc; end
        if (bus.abort)    begin abort_cnt++; last_abort_cyc = cyc; end
        popv = bus.s_tvalid & bus.s_tready;
        model_step(sv, sl, mr);
        @(posedge clk);
        #1;
        drive(popv);
        if (rand_ready) bus.m_tready = ($urandom_range(3) != 0);
        cyc++;
    endtask

    task automatic drain(int budget, string tag);
        int n;
        n = 0;
        while ((pending() || m_own >= 0) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_drain"}, (n < budget), 1);
        repeat (2) cycle();
    endtask

    task automatic wait_hs(int cnt, int budget, string tag);
        int n;
        n = 0;
        while (hs_log.size() < cnt && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_wait"}, (hs_log.size() >= cnt), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NS; k++) begin
            srcq[k].delete();
            exp_bytes[k].delete();
            loaded[k]   = 1'b0;
            gap_left[k] = 0;
        end
        drive('0);
        bus.m_tready = 1'b1;
        rand_ready   = 1'b0;
        m_own = -1; m_last = NS - 1; m_ghold = 0; m_bytes = 0; m_stall = 0;
        m_done_n = 0; m_abort_n = 0; e_done = 1'b0; e_abort = 1'b0;
        hs_log.delete();
        grant_log.delete();
        done_cnt = 0; abort_cnt = 0; bad_rdy = 0; prev_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.s_tdata  = '0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;

        // Reset state
        do_reset();
        repeat (2) cycle();
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);

        // Single message from source 0
        push(0, 8'h24, 0, 0); push(0, 8'h47, 0, 0); push(0, 8'h0A, 1, 0);
        drain(100, "single");
        chk("single_cnt", hs_log.size(), 3);
        chk("single_b0", hs_log[0].data, 8'h24);
        chk("single_b1", hs_log[1].data, 8'h47);
        chk("single_b2", hs_log[2].data, 8'h0A);
        chk("single_src", hs_log[2].src, 0);
        chk("single_done_n", done_cnt, 1);
        chk("single_done_lat", last_done_cyc - hs_log[2].cyc, 1);

        // Contention: both sources valid on the same cycle
        do_reset();
        push(0, 8'hA1, 0, 0); push(0, 8'hA2, 1, 0);
        push(1, 8'hB1, 0, 0); push(1, 8'hB2, 1, 0);
        drain(100, "cont");
        chk("cont_cnt", hs_log.size(), 4);
        chk("cont_src0", hs_log[1].src, 0);
        chk("cont_src1", hs_log[2].src, 1);
        chk("cont_d1", hs_log[1].data, 8'hA2);
        chk("cont_d2", hs_log[2].data, 8'hB1);
        chk("cont_idle_gap", hs_log[2].cyc - hs_log[1].cyc, 2);
        chk("cont_rdy1", bad_rdy, 0);

        // Fairness: both sources request continuously for 6 messages
        do_reset();
        for (int m = 0; m < 3; m++) begin
            push_rand_msg(0, 2);
            push_rand_msg(1, 2);
        end
        for (int k = 0; k < 2; k++) begin
            foreach (srcq[k][i]) srcq[k][i].gap = 0;
        end
        drain(200, "fair");
        chk("fair_n", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("fair_order", grant_log[i], i % 2);
        end

        // Backpressure: m_tready low 50 cycles mid-message
        do_reset();
        push(0, 8'h10, 0, 0); push(0, 8'h11, 0, 0); push(0, 8'h12, 0, 0); push(0, 8'h13, 1, 0);
        wait_hs(2, 20, "bp");
        bus.m_tready = 1'b0;
        repeat (50) cycle();
        bus.m_tready = 1'b1;
        drain(100, "bp");
        chk("bp_abort", abort_cnt, 0);
        chk("bp_cnt", hs_log.size(), 4);
        if (hs_log.size() == 4) begin
            chk("bp_b2", hs_log[2].data, 8'h12);
            chk("bp_b3", hs_log[3].data, 8'h13);
        end

        // Watchdog: source 1 stops mid-message while source 0 waits
        do_reset();
        push(1, 8'h55, 0, 0);
        wait_hs(1, 20, "wd");
        push(0, 8'h66, 0, 0); push(0, 8'h77, 1, 0);
        drain(100, "wd");
        chk("wd_abort_n", abort_cnt, 1);
        chk("wd_abort_lat", last_abort_cyc - (hs_log[0].cyc + 1), 10);
        chk("wd_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("wd_next", grant_log[1], 0);
        if (hs_log.size() == 3) begin
            chk("wd_b1", hs_log[1].data, 8'h66);
            chk("wd_b2", hs_log[2].data, 8'h77);
        end

        // MAX_LEN: 8 bytes without tlast aborts; tlast on the 8th byte completes
        do_reset();
        for (int i = 0; i < ML; i++) push(2, 8'(i), 0, 0);
        for (int i = 0; i < ML; i++) push(2, 8'(8'h80 + i), (i == ML - 1), 0);
        drain(200, "len");
        chk("len_abort_n", abort_cnt, 1);
        chk("len_done_n", done_cnt, 1);
        chk("len_abort_lat", last_abort_cyc - hs_log[ML-1].cyc, 1);
        chk("len_done_lat", last_done_cyc - hs_log[2*ML-1].cyc, 1);

        // Reset asserted while byte 2 of a 4-byte message is on the bus
        do_reset();
        push(0, 8'h01, 0, 0); push(0, 8'h02, 0, 0); push(0, 8'h03, 0, 0); push(0, 8'h04, 1, 0);
        wait_hs(1, 20, "rst");
        chk("rst_pre_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_m_tvalid", bus.m_tvalid, 0);
        chk("rst_async_s_tready", bus.s_tready, 0);
        chk("rst_async_busy", bus.busy, 0);
        do_reset();
        push(0, 8'hC0, 1, 0);
        push(1, 8'hC1, 1, 0);
        drain(100, "rst");
        chk("rst_first_win", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // Randomized traffic with random m_tready and stalls
        do_reset();
        rand_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NS; k++) begin
                int nm;
                nm = $urandom_range(3);
                for (int m = 0; m < nm; m++) push_rand_msg(k, $urandom_range(10, 1));
            end
            drain(4000, "rnd");
        end
        rand_ready   = 1'b0;
        bus.m_tready = 1'b1;
        for (int k = 0; k < NS; k++) begin
            int j;
            j = 0;
            foreach (hs_log[i]) begin
                if (hs_log[i].src == k) begin
                    if (j < exp_bytes[k].size()) chk("rnd_byte", hs_log[i].data, exp_bytes[k][j]);
                    j++;
                end
            end
            chk("rnd_count", j, exp_bytes[k].size());
        end
        chk("rnd_done_n", done_cnt, m_done_n);
        chk("rnd_abort_n", abort_cnt, m_abort_n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
